// File: rtl/hs_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | hs_arb_pkg                                                                 |
// | Shared types and sizing helpers for the handshake channel arbiter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package hs_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_TIMEOUT   = 255;

  // One counter serves both the setup delay and the ack timeout.
  function automatic int cnt_width(input int setup_cyc, input int timeout);
    int a;
    int b;
    a = $clog2(setup_cyc + 1);
    b = $clog2(timeout + 1);
    if (a < 1) a = 1;
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// +----------------------------------------------------------------------------+
// | sync_ff                                                                    |
// | Multi-flop synchronizer for a single asynchronous level, resets to 0.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_ff
  import hs_arb_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hs_channel_arbiter.sv
// +----------------------------------------------------------------------------+
// | hs_channel_arbiter                                                         |
// | Round-robin arbiter driving one 4-phase bundled-data channel.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hs_channel_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          done_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  gnt_idx_o,
  output logic                      req_out_o,
  output logic [DATA_W-1:0]         data_out_o,
  input  logic                      ack_out_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(SETUP_CYC, TIMEOUT);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(N_REQ - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                req_out_q, req_out_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                err_q, err_d;

  logic                w_ack_s;
  logic                w_sel_vld;
  logic [IDX_W-1:0]    w_sel_idx;
  logic [IDX_W-1:0]    w_rr_idx;
  logic                w_to_hit;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_out_i),
    .q_o    (w_ack_s)
  );

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_rr_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rr_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
      if (!w_sel_vld && req_i[w_rr_idx]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_rr_idx;
      end
    end
  end

  assign w_to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    data_out_d = data_out_q;
    req_out_d  = req_out_q;
    done_d     = '0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_sel_vld) begin
          gnt_idx_d  = w_sel_idx;
          ptr_d      = (w_sel_idx == IDX_MAX) ? '0 : w_sel_idx + 1'b1;
          data_out_d = data_i[int'(w_sel_idx)*DATA_W +: DATA_W];
          cnt_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          req_out_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (w_ack_s) begin
          req_out_d = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT_LO;
        end else if (w_to_hit) begin
          req_out_d = 1'b0;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!w_ack_s) begin
          done_d[gnt_idx_q] = 1'b1;
          state_d           = IDLE;
        end else if (w_to_hit) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // The async stage must return to zero before the channel is reused.
        if (!w_ack_s) begin
          done_d[gnt_idx_q] = 1'b1;
          err_d             = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      data_out_q <= '0;
      req_out_q  <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      data_out_q <= data_out_d;
      req_out_q  <= req_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);
  assign gnt_idx_o  = gnt_idx_q;
  assign req_out_o  = req_out_q;
  assign data_out_o = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_hs_channel_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_hs_channel_arbiter                                                      |
// | Directed self-checking bench with a behavioural async ack stage.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hs_channel_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   done;
  logic         err;
  logic         busy;
  logic [1:0]   gnt_idx;
  logic         req_out;
  logic [31:0]  data_out;
  logic         ack;
  bit           ack_en;
  bit           fast;
  int           dly;
  int           errors;
  int           checks;

  hs_channel_arbiter #(
    .N_REQ       (4),
    .DATA_W      (32),
    .SETUP_CYC   (2),
    .SYNC_STAGES (2),
    .TIMEOUT     (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .data_i     (data),
    .done_o     (done),
    .err_o      (err),
    .busy_o     (busy),
    .gnt_idx_o  (gnt_idx),
    .req_out_o  (req_out),
    .data_out_o (data_out),
    .ack_out_i  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async stage: ack follows req after a delay.
  initial begin
    ack = 1'b0;
    forever begin
      @(req_out);
      if (ack_en) begin
        dly = fast ? 3 : int'($urandom_range(20, 1));
        #(dly);
        ack = req_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_req_out(input logic val, input int max, output bit ok);
    int i;
    i  = 0;
    ok = 1'b0;
    while (!ok && i < max) begin
      @(posedge clk); #1;
      if (req_out === val) ok = 1'b1;
      i++;
    end
  endtask

  task automatic wait_done(input int max, output logic [3:0] d, output logic e,
                           output logic [1:0] g, output bit ok);
    int i;
    i  = 0;
    ok = 1'b0;
    d  = '0;
    e  = 1'b0;
    g  = '0;
    while (!ok && i < max) begin
      @(posedge clk); #1;
      if (done !== 4'b0000) begin
        ok = 1'b1;
        d  = done;
        e  = err;
        g  = gnt_idx;
      end
      i++;
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    req    = '0;
    data   = '0;
    ack_en = 1'b1;
    fast   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || req_out !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: busy=%b req_out=%b want 0/0", busy, req_out); end
    checks++; if (done !== 4'b0000 || err !== 1'b0)
      begin errors++; $display("FAIL reset_done: done=%b err=%b want 0000/0", done, err); end
    checks++; if (gnt_idx !== 2'd0)
      begin errors++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx); end
    checks++; if (data_out !== 32'h0)
      begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [3:0]  d;
    logic        e;
    logic [1:0]  g;
    logic [1:0]  exp_idx;
    bit          ok;
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'hC0DE_0000 + k;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_idx = 2'(t % 4);
      wait_done(40, d, e, g, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rr_wait: transfer %0d never completed", t);
      end else begin
        checks++; if (d !== (4'b0001 << exp_idx) || e !== 1'b0)
          begin errors++; $display("FAIL rr_done: t=%0d done=%b err=%b want %b/0", t, d, e, 4'b0001 << exp_idx); end
        checks++; if (g !== exp_idx)
          begin errors++; $display("FAIL rr_gnt: t=%0d got %0d want %0d", t, g, exp_idx); end
        checks++; if (data_out !== 32'hC0DE_0000 + 32'(exp_idx))
          begin errors++; $display("FAIL rr_data: t=%0d got %h want %h", t, data_out, 32'hC0DE_0000 + 32'(exp_idx)); end
        checks++; if (busy !== 1'b0)
          begin errors++; $display("FAIL rr_no_b2b: busy=%b on done edge want 0", busy); end
      end
      if (t == 7) req = 4'b0000;
      @(posedge clk); #1;
      checks++; if (done !== 4'b0000)
        begin errors++; $display("FAIL rr_pulse: done=%b one cycle later want 0000", done); end
    end
  endtask

  task automatic test_single;
    logic [3:0] d;
    logic       e;
    logic [1:0] g;
    bit         ok;
    data[64 +: 32] = 32'hDEAD_BEEF;
    req = 4'b0100;
    @(posedge clk); #1;
    checks++; if (gnt_idx !== 2'd2 || data_out !== 32'hDEAD_BEEF || req_out !== 1'b0)
      begin errors++; $display("FAIL single_grant: gnt=%0d data=%h req_out=%b want 2/deadbeef/0", gnt_idx, data_out, req_out); end
    @(posedge clk); #1;
    checks++; if (req_out !== 1'b0)
      begin errors++; $display("FAIL single_setup: req_out=%b at E1 want 0", req_out); end
    @(posedge clk); #1;
    checks++; if (req_out !== 1'b1)
      begin errors++; $display("FAIL single_rise: req_out=%b at E2 want 1", req_out); end
    wait_done(40, d, e, g, ok);
    checks++; if (!ok || d !== 4'b0100 || e !== 1'b0)
      begin errors++; $display("FAIL single_done: ok=%b done=%b err=%b want 1/0100/0", ok, d, e); end
    req = 4'b0000;
    @(posedge clk); #1;
    checks++; if (done !== 4'b0000)
      begin errors++; $display("FAIL single_pulse: done=%b want 0000", done); end
  endtask

  task automatic test_fast_ack;
    logic       r  [1:8];
    logic [3:0] dn [1:8];
    bit         stable;
    fast = 1'b1;
    data[0 +: 32] = 32'h1234_5678;
    req = 4'b0001;
    @(posedge clk); #1;
    checks++; if (gnt_idx !== 2'd0 || data_out !== 32'h1234_5678)
      begin errors++; $display("FAIL fast_grant: gnt=%0d data=%h want 0/12345678", gnt_idx, data_out); end
    stable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      r[k]  = req_out;
      dn[k] = done;
      if (data_out !== 32'h1234_5678) stable = 1'b0;
    end
    req = 4'b0000;
    checks++; if (r[1] !== 1'b0 || r[2] !== 1'b1 || r[4] !== 1'b1 || r[5] !== 1'b0)
      begin errors++; $display("FAIL fast_req_timing: E1..E5 req_out=%b%b%b%b%b want 01110", r[1], r[2], r[3], r[4], r[5]); end
    checks++; if (dn[7] !== 4'b0000 || dn[8] !== 4'b0001)
      begin errors++; $display("FAIL fast_done_timing: E7=%b E8=%b want 0000/0001", dn[7], dn[8]); end
    checks++; if (!stable)
      begin errors++; $display("FAIL fast_data_stable: data_out changed during handshake, want 12345678"); end
    @(posedge clk); #1;
    fast = 1'b0;
  endtask

  task automatic test_timeout;
    logic [3:0] d;
    logic       e;
    logic [1:0] g;
    bit         ok;
    int         n;
    ack_en = 1'b0;
    req = 4'b0010;
    wait_req_out(1'b1, 10, ok);
    checks++; if (!ok)
      begin errors++; $display("FAIL to_rise: req_out never rose"); end
    n = 0;
    while (req_out === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 8)
      begin errors++; $display("FAIL to_len: req_out high %0d cycles want 8", n); end
    checks++; if (done !== 4'b0000 || err !== 1'b0)
      begin errors++; $display("FAIL to_early: done=%b err=%b on fall edge want 0000/0", done, err); end
    @(posedge clk); #1;
    checks++; if (done !== 4'b0010 || err !== 1'b1)
      begin errors++; $display("FAIL to_err: done=%b err=%b want 0010/1", done, err); end
    req = 4'b0000;
    ack_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (err !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL to_clear: err=%b busy=%b want 0/0", err, busy); end
    data[96 +: 32] = 32'hFEED_F00D;
    req = 4'b1000;
    wait_done(40, d, e, g, ok);
    checks++; if (!ok || d !== 4'b1000 || e !== 1'b0 || data_out !== 32'hFEED_F00D)
      begin errors++; $display("FAIL to_next: ok=%b done=%b err=%b data=%h want 1/1000/0/feedf00d", ok, d, e, data_out); end
    req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [3:0] d;
    logic       e;
    logic [1:0] g;
    bit         ok;
    req = 4'b0001;
    wait_req_out(1'b1, 10, ok);
    checks++; if (!ok)
      begin errors++; $display("FAIL rstmid_rise: req_out never rose"); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_out !== 1'b0 || busy !== 1'b0 || done !== 4'b0000)
      begin errors++; $display("FAIL rstmid_async: req_out=%b busy=%b done=%b want 0/0/0000", req_out, busy, done); end
    req = 4'b0110;
    #2;
    rst_n = 1'b1;
    wait_done(40, d, e, g, ok);
    checks++; if (!ok || d !== 4'b0010 || g !== 2'd1 || e !== 1'b0)
      begin errors++; $display("FAIL rstmid_first: ok=%b done=%b gnt=%0d err=%b want 1/0010/1/0", ok, d, g, e); end
    req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_drop_in_wait_lo;
    logic [3:0] d;
    logic       e;
    logic [1:0] g;
    bit         ok1;
    bit         ok2;
    bit         ok;
    bit         spurious;
    fast = 1'b1;
    req = 4'b0010;
    wait_req_out(1'b1, 10, ok1);
    wait_req_out(1'b0, 10, ok2);
    checks++; if (!ok1 || !ok2)
      begin errors++; $display("FAIL drop_hs: rise=%b fall=%b want 1/1", ok1, ok2); end
    req = 4'b0000;
    wait_done(10, d, e, g, ok);
    checks++; if (!ok || d !== 4'b0010 || e !== 1'b0)
      begin errors++; $display("FAIL drop_done: ok=%b done=%b err=%b want 1/0010/0", ok, d, e); end
    spurious = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 4'b0000) spurious = 1'b1;
    end
    checks++; if (spurious)
      begin errors++; $display("FAIL drop_spurious: extra grant or done after drop, want none"); end
    fast = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_fast_ack();
    test_timeout();
    test_reset_mid();
    test_drop_in_wait_lo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
